// File: rtl/store_buffer_ctrl.sv
// Posted-write store buffer: aligns and lane-places SB/SH/SW stores, queues them in a
// DEPTH-entry FIFO and drains them to data memory over a req/ack handshake.
module store_buffer_ctrl #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       st_valid,
  input  logic                       st_byte,
  input  logic                       st_hw,
  input  logic                       st_word,
  input  logic [31:0]                st_addr,
  input  logic [31:0]                st_data,
  output logic                       st_ready,
  input  logic                       drain,
  output logic                       drain_done,
  input  logic                       ld_check,
  input  logic [31:0]                ld_addr,
  output logic                       ld_hazard,
  output logic                       mem_req,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  output logic [3:0]                 mem_be,
  input  logic                       mem_ack,
  output logic                       misalign_err,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {IDLE, REQ} state_t;

  state_t              state;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [DEPTH-1:0]    ent_vld;
  logic [29:0]         ent_addr [DEPTH];
  logic [31:0]         ent_data [DEPTH];
  logic [3:0]          ent_be   [DEPTH];
  logic                drain_fired;

  logic                sz_any;
  logic                aligned;
  logic [31:0]         lane_data;
  logic [3:0]          lane_be;
  logic                push;
  logic                pop;
  logic [CW-1:0]       count_nxt;

  always_comb begin
    sz_any    = st_byte | st_hw | st_word;
    aligned   = 1'b1;
    lane_data = st_data;
    lane_be   = 4'b1111;
    if (st_byte) begin
      lane_data = {4{st_data[7:0]}};
      lane_be   = 4'b0001 << st_addr[1:0];
    end else if (st_hw) begin
      aligned   = ~st_addr[0];
      lane_data = {2{st_data[15:0]}};
      lane_be   = st_addr[1] ? 4'b1100 : 4'b0011;
    end else begin
      aligned   = (st_addr[1:0] == 2'b00);
    end
  end

  // Ready comes only from the registered count, so a pop cannot free a slot for a same-cycle push
  assign st_ready  = (count < CW'(DEPTH)) & ~drain;
  assign push      = st_valid & st_ready & sz_any & aligned;
  assign pop       = (state == REQ) & mem_ack;
  assign count_nxt = count + CW'(push) - CW'(pop);

  assign mem_req   = (state == REQ);
  assign mem_addr  = mem_req ? {ent_addr[rd_ptr], 2'b00} : '0;
  assign mem_wdata = mem_req ? ent_data[rd_ptr] : '0;
  assign mem_be    = mem_req ? ent_be[rd_ptr] : '0;

  // Comparing the full address with its own low bits keeps the match on word granularity
  always_comb begin
    ld_hazard = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && ({ent_addr[i], ld_addr[1:0]} == ld_addr)) ld_hazard = 1'b1;
    end
    ld_hazard = ld_hazard & ld_check;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[wr_ptr] <= st_addr[31:2];
      ent_data[wr_ptr] <= lane_data;
      ent_be[wr_ptr]   <= lane_be;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      ent_vld      <= '0;
      misalign_err <= 1'b0;
      drain_done   <= 1'b0;
      drain_fired  <= 1'b0;
    end else begin
      count        <= count_nxt;
      misalign_err <= st_valid & sz_any & ~aligned;
      if (push) begin
        ent_vld[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) begin
        ent_vld[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + 1'b1;
      end
      case (state)
        IDLE: if (count != '0) state <= REQ;
        REQ:  if (pop && (count_nxt == '0)) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (drain && (count == '0) && (state == IDLE) && !drain_fired) begin
        drain_done  <= 1'b1;
        drain_fired <= 1'b1;
      end else begin
        drain_done  <= 1'b0;
        if (!drain) drain_fired <= 1'b0;
      end
    end
  end

endmodule
